apb_arbiter: RTL and testbench
==============================

# apb_arbiter

Two-requester APB master sequencer that shares the single APB bus between two independent transaction sources, such as a CPU port and a DMA/test port, and the GPIO and UART slaves. It arbitrates round-robin and drives the IDLE/SETUP/ACCESS phases. It decodes the 2-bit slave select into per-slave PSEL strobes, muxes each slave's PREADY/PRDATA back, and returns completion, read data and error status to the winning requester.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 16, ACCESS wait-cycle limit; used only with the timeout feature

Ports:
- pclk  in  1  bus clock; all logic is rising-edge
- Reset  in  1  synchronous, active-high reset
- req0 / req1  in  1  request; held high until the matching done
- sel0 / sel1  in  2  slave select: 1 = GPIO, 2 = UART, 0/3 = invalid
- write0 / write1  in  1  1 = write, 0 = read
- addr0 / addr1  in  ADDR_W  transfer address
- wdata0 / wdata1  in  DATA_W  write data
- done0 / done1  out  1  one-cycle completion pulse
- err0 / err1  out  1  valid with done: decode error or timeout
- rdata0 / rdata1  out  DATA_W  read data; registered, held until the next done to that requester
- psel1 / psel2  out  1  GPIO / UART select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- paddr  out  ADDR_W  APB address
- pwdata  out  DATA_W  APB write data
- pready1 / pready2  in  1  slave ready
- prdata1 / prdata2  in  DATA_W  slave read data

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: eligible requesters are those with req high and done low in the same cycle. If none are eligible, stay in IDLE.
  - One eligible: grant it.
  - Both eligible: grant the one not granted last. The last-grant register resets to 1, so req0 wins the first tie.
  - On grant, latch sel/write/addr/wdata into an internal transfer register.
  - Invalid sel (0 or 3): no bus cycle. done and err pulse on the next cycle; the FSM stays in IDLE.
  - Valid sel: go to SETUP.
- SETUP: drive the selected psel high and penable low; the other psel is 0. paddr, pwrite and pwdata come from the transfer register. Unconditionally go to ACCESS.
- ACCESS: penable is high; psel and bus fields are unchanged. pready/prdata are taken from the selected slave only.
  - pready high at the clock edge: capture prdata into the granted rdata (on reads only; writes leave rdata unchanged). done pulses next cycle with err = 0. Go to IDLE.
  - pready low: stay in ACCESS.
- The non-granted requester's outputs never change.
- An active req may not change its fields while pending; behaviour is undefined otherwise.

## Timing
- Reset values (synchronous): state = IDLE; psel1, psel2, penable, pwrite = 0; paddr, pwdata = 0; done*, err* = 0; rdata* = 0; last-grant = 1.
- Reset asserted mid-transfer: bus is idle at the next edge, the transfer is abandoned, and no done is issued.
- Minimum latency, zero-wait slave: req sampled in IDLE at edge 0, SETUP at cycles 1–2, ACCESS at cycles 2–3, done high in cycle 3.
  - Each pready-low ACCESS cycle adds one cycle.
- done coincides with IDLE, so a different pending requester can be granted in the same cycle done is high. Back-to-back transfer period is 3 cycles.
- Decode-error latency: done/err one cycle after the IDLE sample.
- psel*/penable/paddr are registered outputs; there are no combinational paths from req to the bus.

## Configuration
- APB_ARB_TIMEOUT_EN defined:
  - A wait counter clears on entering ACCESS and increments on each pready-low ACCESS cycle.
  - When it reaches TIMEOUT, the next edge drops psel/penable, pulses done with err = 1 (rdata unchanged), and returns to IDLE.
- APB_ARB_TIMEOUT_EN undefined: no counter; ACCESS waits for pready indefinitely.

## Structure
- Package apb_arb_pkg:
  - state enum (ST_IDLE, ST_SETUP, ST_ACCESS)
  - select codes SEL_NONE = 0, SEL_GPIO = 1, SEL_UART = 2
  - default TIMEOUT
- Sub-module apb_rr_arb2: 2-way round-robin grant. Inputs are the eligible requests, the last-grant value and an update strobe; output is a one-hot grant.

## Test plan
- Reset then req0 write, sel = 1, addr = 0x4, wdata = 0xA5, zero-wait GPIO -> psel1 high cycles 1–2, penable high cycle 2, done0 in cycle 3, err0 = 0.
- req1 read, sel = 2, UART pready low for 3 ACCESS cycles, prdata2 = 0x55 -> done1 six cycles after sample, rdata1 = 0x55.
- req0 and req1 high in the same cycle, both held for repeated transfers -> grant order 0, 1, 0, 1; each done only to its owner.
- req0 with sel = 3 -> no psel, done0 and err0 one cycle later.
- Reset asserted during ACCESS -> all bus outputs 0 next edge, no done.
- With APB_ARB_TIMEOUT_EN, TIMEOUT = 4, pready held low -> done with err = 1 after 4 wait cycles, bus idle; without the macro, still waiting at cycle 50.

Source files
------------

// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the two-requester APB arbiter.
// Optional ACCESS timeout is enabled by defining APB_ARB_TIMEOUT_EN.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS
    } state_e;

    localparam logic [1:0] SEL_NONE = 2'd0;
    localparam logic [1:0] SEL_GPIO = 2'd1;
    localparam logic [1:0] SEL_UART = 2'd2;

    localparam int TIMEOUT_DEF = 16;

    function automatic logic sel_valid(input logic [1:0] s);
        return (s == SEL_GPIO) || (s == SEL_UART);
    endfunction

endpackage

// File: rtl/apb_rr_arb2.sv
// Two-way round-robin grant; ties go to the requester not granted last.
// Grant is forced to zero when the update strobe is low.
module apb_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       upd,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (upd) begin
            unique case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/apb_arbiter.sv
// Two-requester APB master: round-robin grant, SETUP/ACCESS sequencing.
// Define APB_ARB_TIMEOUT_EN to abort ACCESS after TIMEOUT wait cycles.
module apb_arbiter
    import apb_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              pclk,
    input  logic              Reset,
    input  logic              req0,
    input  logic              req1,
    input  logic [1:0]        sel0,
    input  logic [1:0]        sel1,
    input  logic              write0,
    input  logic              write1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              done0,
    output logic              done1,
    output logic              err0,
    output logic              err1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              psel1,
    output logic              psel2,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic              pready1,
    input  logic              pready2,
    input  logic [DATA_W-1:0] prdata1,
    input  logic [DATA_W-1:0] prdata2
);

    state_e            state_q, state_d;
    logic              last_q, last_d;
    logic              owner_q, owner_d;
    logic              psel1_q, psel1_d;
    logic              psel2_q, psel2_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              done0_q, done0_d;
    logic              done1_q, done1_d;
    logic              err0_q, err0_d;
    logic              err1_q, err1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    logic [1:0]        elig;
    logic [1:0]        gnt;
    logic              take;
    logic [1:0]        tsel;
    logic              rdy;
    logic [DATA_W-1:0] rdat;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
`endif

    // A requester whose done is showing this cycle is already satisfied.
    assign elig = {req1 & ~done1_q, req0 & ~done0_q};

    apb_rr_arb2 u_arb (
        .req  (elig),
        .last (last_q),
        .upd  (state_q == ST_IDLE),
        .gnt  (gnt)
    );

    assign take = gnt[1];
    assign tsel = take ? sel1 : sel0;
    assign rdy  = psel1_q ? pready1 : pready2;
    assign rdat = psel1_q ? prdata1 : prdata2;

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        owner_d   = owner_q;
        psel1_d   = psel1_q;
        psel2_d   = psel2_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        done0_d   = 1'b0;
        done1_d   = 1'b0;
        err0_d    = 1'b0;
        err1_d    = 1'b0;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
`ifdef APB_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (|gnt) begin
                    last_d  = take;
                    owner_d = take;
                    if (sel_valid(tsel)) begin
                        state_d  = ST_SETUP;
                        psel1_d  = (tsel == SEL_GPIO);
                        psel2_d  = (tsel == SEL_UART);
                        pwrite_d = take ? write1 : write0;
                        paddr_d  = take ? addr1 : addr0;
                        pwdata_d = take ? wdata1 : wdata0;
                    end else begin
                        done0_d = ~take;
                        done1_d = take;
                        err0_d  = ~take;
                        err1_d  = take;
                    end
                end
            end
            ST_SETUP: begin
                state_d   = ST_ACCESS;
                penable_d = 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
                cnt_d     = '0;
`endif
            end
            ST_ACCESS: begin
                if (rdy) begin
                    state_d   = ST_IDLE;
                    psel1_d   = 1'b0;
                    psel2_d   = 1'b0;
                    penable_d = 1'b0;
                    done0_d   = ~owner_q;
                    done1_d   = owner_q;
                    if (!pwrite_q) begin
                        if (owner_q) rdata1_d = rdat;
                        else         rdata0_d = rdat;
                    end
`ifdef APB_ARB_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    state_d   = ST_IDLE;
                    psel1_d   = 1'b0;
                    psel2_d   = 1'b0;
                    penable_d = 1'b0;
                    done0_d   = ~owner_q;
                    done1_d   = owner_q;
                    err0_d    = ~owner_q;
                    err1_d    = owner_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            last_q    <= 1'b1;
            owner_q   <= 1'b0;
            psel1_q   <= 1'b0;
            psel2_q   <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
`ifdef APB_ARB_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            owner_q   <= owner_d;
            psel1_q   <= psel1_d;
            psel2_q   <= psel2_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            done0_q   <= done0_d;
            done1_q   <= done1_d;
            err0_q    <= err0_d;
            err1_q    <= err1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
`ifdef APB_ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign done0   = done0_q;
    assign done1   = done1_q;
    assign err0    = err0_q;
    assign err1    = err1_q;
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;
    assign psel1   = psel1_q;
    assign psel2   = psel2_q;
    assign penable = penable_q;
    assign pwrite  = pwrite_q;
    assign paddr   = paddr_q;
    assign pwdata  = pwdata_q;

endmodule

// File: tb/tb_apb_arbiter.sv
// Bench for apb_arbiter: directed scenarios, then random traffic
// checked cycle by cycle against a transaction-level timeline model.
module tb_apb_arbiter;

    localparam int TMO = 4;
    localparam int NC  = 1500;

    logic        pclk = 1'b0;
    logic        rst;
    logic        req0, req1;
    logic [1:0]  sel0, sel1;
    logic        write0, write1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        done0, done1, err0, err1;
    logic [31:0] rdata0, rdata1;
    logic        psel1, psel2, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic        pready1, pready2;
    logic [31:0] prdata1, prdata2;

    int n_checks = 0;
    int n_errors = 0;

    // Expected per-cycle timeline for the random phase.
    logic        e_psel [2][NC];
    logic        e_pen  [NC];
    logic        e_done [2][NC];
    logic        e_err  [2][NC];
    logic        e_pwr  [NC];
    logic [31:0] e_paddr[NC];
    logic [31:0] e_pwd  [NC];
    logic [31:0] e_rd   [2][NC];

    logic        r_req [2];
    logic [1:0]  r_sel [2];
    logic        r_wr  [2];
    logic [31:0] r_addr[2];
    logic [31:0] r_wd  [2];

    int          m_free, m_last, o, w, s, n_done;
    int          w_lo, w_hi, w_sel;
    logic [31:0] w_data;
    logic        el0, el1, d_err;

    apb_arbiter #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(TMO)
    ) dut (
        .pclk    (pclk),
        .Reset   (rst),
        .req0    (req0),
        .req1    (req1),
        .sel0    (sel0),
        .sel1    (sel1),
        .write0  (write0),
        .write1  (write1),
        .addr0   (addr0),
        .addr1   (addr1),
        .wdata0  (wdata0),
        .wdata1  (wdata1),
        .done0   (done0),
        .done1   (done1),
        .err0    (err0),
        .err1    (err1),
        .rdata0  (rdata0),
        .rdata1  (rdata1),
        .psel1   (psel1),
        .psel2   (psel2),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .pready1 (pready1),
        .pready2 (pready2),
        .prdata1 (prdata1),
        .prdata2 (prdata2)
    );

    always #5 pclk = ~pclk;

    task automatic tick;
        @(posedge pclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        req0 = 0; req1 = 0; sel0 = 0; sel1 = 0;
        write0 = 0; write1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        pready1 = 0; pready2 = 0; prdata1 = 0; prdata2 = 0;
        tick; tick;
        rst = 1'b0;
        tick;
        chk("rst_ctl", 64'({psel1, psel2, penable, pwrite,
                            done0, done1, err0, err1}), 64'(0));
        chk("rst_bus", {paddr, pwdata}, 64'(0));
        chk("rst_rd", {rdata0, rdata1}, 64'(0));

        // Zero-wait GPIO write from requester 0.
        req0 = 1; sel0 = 2'd1; write0 = 1; addr0 = 32'h4; wdata0 = 32'hA5;
        pready1 = 1; prdata1 = 32'hDEAD_BEEF;
        tick;
        chk("t1_setup", 64'({psel1, psel2, penable, pwrite}), 64'(4'b1001));
        chk("t1_fields", {paddr, pwdata}, {32'h4, 32'hA5});
        tick;
        chk("t1_access", 64'({psel1, psel2, penable, done0}), 64'(4'b1010));
        tick;
        chk("t1_done", 64'({done0, err0, done1, psel1, penable}),
            64'(5'b10000));
        chk("t1_rdata", 64'(rdata0), 64'(0));
        req0 = 0;
        tick;

        // UART read with three wait cycles; GPIO ready must be ignored.
        req1 = 1; sel1 = 2'd2; write1 = 0; addr1 = 32'h8;
        prdata2 = 32'h1234_0000;
        for (int k = 1; k <= 6; k++) begin
            tick;
            if (k < 6) chk($sformatf("t2_wait%0d", k), 64'({done1, done0}),
                           64'(0));
            if (k == 3) chk("t2_psel", 64'({psel1, psel2, penable}),
                            64'(3'b011));
            pready2 = (k == 5);
            prdata2 = (k == 5) ? 32'h55 : 32'h1234_0000 + k;
        end
        chk("t2_done", 64'({done1, err1}), 64'(2'b10));
        chk("t2_rdata", 64'(rdata1), 64'(32'h55));
        req1 = 0; pready2 = 0;
        tick;

        // Invalid select: no bus cycle, done+err next cycle.
        req0 = 1; sel0 = 2'd3; write0 = 0;
        tick;
        chk("t3_err", 64'({done0, err0, psel1, psel2}), 64'(4'b1100));
        req0 = 0;
        tick;
        chk("t3_clr", 64'({done0, err0, psel1, psel2, penable}), 64'(0));
        chk("t3_rdata", 64'(rdata0), 64'(0));

        // Both held: alternating grants starting with requester 0.
        rst = 1;
        tick;
        rst = 0;
        req0 = 1; req1 = 1; sel0 = 2'd1; sel1 = 2'd2;
        write0 = 1; write1 = 1; pready1 = 1; pready2 = 1;
        for (int k = 1; k <= 12; k++) begin
            tick;
            chk($sformatf("t4_rr%0d", k), 64'({done1, done0}),
                64'((k % 3 != 0) ? 2'b00 : ((k % 6 == 3) ? 2'b01 : 2'b10)));
        end
        req0 = 0; req1 = 0;
        tick; tick;

        // Reset while in ACCESS abandons the transfer.
        req0 = 1; sel0 = 2'd2; write0 = 1; addr0 = 32'hC; wdata0 = 32'h77;
        pready2 = 0;
        tick; tick;
        chk("t5_access", 64'({psel2, penable}), 64'(2'b11));
        rst = 1;
        tick;
        chk("t5_rst_ctl", 64'({psel1, psel2, penable, pwrite, done0, err0}),
            64'(0));
        chk("t5_rst_bus", {paddr, pwdata}, 64'(0));
        rst = 0; req0 = 0;
        tick;
        chk("t5_nodone_a", 64'(done0), 64'(0));
        tick;
        chk("t5_nodone_b", 64'(done0), 64'(0));

        // Slave never ready.
        req0 = 1; sel0 = 2'd1; write0 = 0; addr0 = 32'h10;
        pready1 = 0; prdata1 = 32'hFFFF;
        n_done = 0; d_err = 0;
        for (int k = 1; k <= 50; k++) begin
            tick;
            if (done0) begin
                n_done++;
                d_err = err0;
                req0 = 0;
            end
        end
`ifdef APB_ARB_TIMEOUT_EN
        chk("t6_tmo_done", 64'(n_done), 64'(1));
        chk("t6_tmo_err", 64'(d_err), 64'(1));
        chk("t6_tmo_idle", 64'({psel1, penable}), 64'(0));
        chk("t6_tmo_rd", 64'(rdata0), 64'(0));
`else
        chk("t6_nodone", 64'(n_done), 64'(0));
        chk("t6_waiting", 64'({psel1, penable}), 64'(2'b11));
`endif

        // Random traffic against the timeline model.
        rst = 1; req0 = 0; req1 = 0;
        tick;
        rst = 0;
        for (int k = 0; k < NC; k++) begin
            e_pen[k] = 0; e_pwr[k] = 0; e_paddr[k] = 0; e_pwd[k] = 0;
            for (int i = 0; i < 2; i++) begin
                e_psel[i][k] = 0; e_done[i][k] = 0;
                e_err[i][k] = 0; e_rd[i][k] = 0;
            end
        end
        for (int i = 0; i < 2; i++) begin
            r_req[i] = 0; r_sel[i] = 0; r_wr[i] = 0;
            r_addr[i] = 0; r_wd[i] = 0;
        end
        m_free = 0; m_last = 1; w_lo = -1; w_hi = -1; w_sel = 0; w_data = 0;

        for (int t = 0; t < NC - 8; t++) begin
            chk($sformatf("ctl@%0d", t),
                64'({psel1, psel2, penable, done0, done1, err0, err1}),
                64'({e_psel[0][t], e_psel[1][t], e_pen[t], e_done[0][t],
                     e_done[1][t], e_err[0][t], e_err[1][t]}));
            chk($sformatf("bus@%0d", t), 64'({pwrite, paddr, pwdata}),
                64'({e_pwr[t], e_paddr[t], e_pwd[t]}));
            chk($sformatf("rd@%0d", t), {rdata0, rdata1},
                {e_rd[0][t], e_rd[1][t]});

            for (int i = 0; i < 2; i++) begin
                if (r_req[i] && e_done[i][t]) r_req[i] = 0;
                if (!r_req[i] && $urandom_range(0, 2) == 0) begin
                    s = $urandom_range(0, 7);
                    r_sel[i]  = (s < 3) ? 2'd1 : (s < 6) ? 2'd2 :
                                (s == 6) ? 2'd0 : 2'd3;
                    r_wr[i]   = 1'($urandom_range(0, 1));
                    r_addr[i] = $urandom;
                    r_wd[i]   = $urandom;
                    r_req[i]  = 1;
                end
            end

            if (t >= m_free) begin
                el0 = r_req[0] && !e_done[0][t];
                el1 = r_req[1] && !e_done[1][t];
                if (el0 || el1) begin
                    o = (el0 && el1) ? 1 - m_last : (el1 ? 1 : 0);
                    m_last = o;
                    s = int'(r_sel[o]);
                    if (s == 1 || s == 2) begin
                        w = $urandom_range(0, 4);
                        for (int k = t + 1; k <= t + 2 + w; k++)
                            e_psel[s-1][k] = 1;
                        for (int k = t + 2; k <= t + 2 + w; k++)
                            e_pen[k] = 1;
                        for (int k = t + 1; k < NC; k++) begin
                            e_pwr[k]   = r_wr[o];
                            e_paddr[k] = r_addr[o];
                            e_pwd[k]   = r_wd[o];
                        end
                        e_done[o][t+3+w] = 1;
                        w_lo = t + 2; w_hi = t + 2 + w; w_sel = s;
                        w_data = $urandom;
                        if (!r_wr[o])
                            for (int k = t + 3 + w; k < NC; k++)
                                e_rd[o][k] = w_data;
                        m_free = t + 3 + w;
                    end else begin
                        e_done[o][t+1] = 1;
                        e_err[o][t+1]  = 1;
                        m_free = t + 1;
                    end
                end
            end

            pready1 = 1'($urandom_range(0, 1));
            pready2 = 1'($urandom_range(0, 1));
            prdata1 = $urandom;
            prdata2 = $urandom;
            if (t >= w_lo && t <= w_hi) begin
                if (w_sel == 1) begin
                    pready1 = (t == w_hi);
                    if (t == w_hi) prdata1 = w_data;
                end else begin
                    pready2 = (t == w_hi);
                    if (t == w_hi) prdata2 = w_data;
                end
            end

            req0 = r_req[0]; sel0 = r_sel[0]; write0 = r_wr[0];
            addr0 = r_addr[0]; wdata0 = r_wd[0];
            req1 = r_req[1]; sel1 = r_sel[1]; write1 = r_wr[1];
            addr1 = r_addr[1]; wdata1 = r_wd[1];
            tick;
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
